// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath enables and mux selects combinationally from the state.
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd15;

  logic [3:0] state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else                                    state_d = S_HALT;
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs depend on state_q only (plus mem_ready), so async reset clears them at once.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT:  illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks every instruction class, stalls, HALT and async reset.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],instr_done,illegal_op}
  logic [17:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  localparam logic [17:0] V_ZERO   = 18'b0;
  localparam logic [17:0] V_FETCH1 = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_FETCH0 = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] V_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] V_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] V_MEMWR1 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] V_MEMWR0 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] V_ALUWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] V_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] V_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] V_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] V_HALT   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [3:0] st, input logic [17:0] v);
    check({tag, ".state"}, {28'd0, state}, {28'd0, st});
    check({tag, ".outs"}, {14'd0, outs}, {14'd0, v});
  endtask

  // Advance one cycle and sample on the falling edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [17:0] v);
    @(negedge clk);
    expect_now(tag, st, v);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
    repeat (3) @(negedge clk);
    expect_now("in_reset", 4'd0, V_ZERO);
    rst_n = 1'b1;
    expect_now("idle_after_rel", 4'd0, V_ZERO);

    // LW: 0,1,2,3,4,5
    step("lw.fetch", 4'd1, V_FETCH1);
    step("lw.decode", 4'd2, V_DECODE);
    step("lw.memadr", 4'd3, V_MEMADR);
    step("lw.memrd", 4'd4, V_MEMRD);
    step("lw.memwb", 4'd5, V_MEMWB);

    opcode = 6'b000000;
    step("r.fetch", 4'd1, V_FETCH1);
    step("r.decode", 4'd2, V_DECODE);
    step("r.exec", 4'd7, V_EXEC);
    step("r.aluwb", 4'd8, V_ALUWB);

    opcode = 6'b000100;
    step("beq.fetch", 4'd1, V_FETCH1);
    step("beq.decode", 4'd2, V_DECODE);
    step("beq.branch", 4'd9, V_BRANCH);

    opcode = 6'b000010;
    step("j.fetch", 4'd1, V_FETCH1);
    step("j.decode", 4'd2, V_DECODE);
    step("j.jump", 4'd10, V_JUMP);

    opcode = 6'b001000;
    step("addi.fetch", 4'd1, V_FETCH1);
    step("addi.decode", 4'd2, V_DECODE);
    step("addi.ex", 4'd11, V_MEMADR);
    step("addi.wb", 4'd12, V_ADDIWB);

    // SW with three MEMWR stall cycles; mem_ready low in MEMADR must be ignored.
    opcode = 6'b101011;
    step("sw.fetch", 4'd1, V_FETCH1);
    step("sw.decode", 4'd2, V_DECODE);
    step("sw.memadr", 4'd3, V_MEMADR);
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) step("sw.memwr_stall", 4'd6, V_MEMWR0);
    mem_ready = 1'b1;
    #1 expect_now("sw.memwr_done", 4'd6, V_MEMWR1);

    // FETCH stalled two cycles, then an illegal opcode.
    opcode = 6'b111111;
    @(posedge clk); #1 mem_ready = 1'b0;
    step("stall.fetch0", 4'd1, V_FETCH0);
    step("stall.fetch1", 4'd1, V_FETCH0);
    mem_ready = 1'b1;
    #1 expect_now("stall.fetch_go", 4'd1, V_FETCH1);
    step("ill.decode", 4'd2, V_DECODE);
    for (int unsigned i = 0; i < 4; i++) begin
      mem_ready = i[0];
      step("ill.halt", 4'd15, V_HALT);
    end
    mem_ready = 1'b1;

    // Reset pulse out of HALT.
    rst_n = 1'b0;
    #1 expect_now("halt.reset", 4'd0, V_ZERO);
    @(negedge clk);
    opcode = 6'b100011;
    rst_n = 1'b1;
    expect_now("halt.rel_idle", 4'd0, V_ZERO);
    step("lw2.fetch", 4'd1, V_FETCH1);
    step("lw2.decode", 4'd2, V_DECODE);
    step("lw2.memadr", 4'd3, V_MEMADR);
    mem_ready = 1'b0;
    step("lw2.memrd", 4'd4, V_MEMRD);
    step("lw2.memrd_wait", 4'd4, V_MEMRD);

    // Async reset mid-cycle during MEMRD.
    #2 rst_n = 1'b0;
    #1 expect_now("async_rst", 4'd0, V_ZERO);
    check("async_rst.MemRead", {31'd0, MemRead}, 32'd0);
    @(negedge clk);
    expect_now("async_rst.held", 4'd0, V_ZERO);
    mem_ready = 1'b1;
    rst_n = 1'b1;
    step("post_rst.fetch", 4'd1, V_FETCH1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
Multicycle main control FSM for the 10-instruction MIPS multicycle core. It sequences fetch, decode, execute, memory and writeback for each instruction, driving datapath enables and muxes. It produces the 2-bit ALUOp consumed directly by the downstream ALU control unit: 00 = add, 01 = subtract, 10 = decode from the funct field. It supports a memory handshake via mem_ready.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, add-immediate opcode

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
MemtoReg  out  1  writeback select: 1 = MDR, 0 = ALUOut
RegDst  out  1  destination register select: 1 = rd, 0 = rt
RegWrite  out  1  register file write
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
ALUOp  out  2  to ALU control: 00 add, 01 sub, 10 funct
PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  final cycle of an instruction
illegal_op  out  1  sticky unsupported-opcode flag
state  out  4  current state, for debug

Behaviour:
- Single clock domain. State register is reset asynchronously by rst_n = 0 to IDLE (4'd0).
- Outputs are decoded combinationally from state, plus mem_ready where noted. Any output not listed for a state is 0.
- Reset values: all outputs 0 and state = 0.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12, HALT 15. Codes 13 and 14 are unused and go to IDLE on the next edge.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - PCWrite = IRWrite = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. opcode is sampled this cycle. Next state by opcode:
  - LW or SW → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDIEX
  - any other opcode → HALT
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD for LW, MEMWR for SW (opcode still held stable by IR).
- MEMRD: MemRead = 1, IorD = 1. Waits while mem_ready = 0, then goes to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0, instr_done = 1. Next state is FETCH.
- MEMWR: MemWrite = 1, IorD = 1, instr_done = mem_ready. Waits while mem_ready = 0, then goes to FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state is ALUWB.
- ALUWB: RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1. Next state is FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1. Next state is FETCH.
- JUMP: PCWrite = 1, PCSource = 10, instr_done = 1. Next state is FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state is ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1. Next state is FETCH.
- HALT: illegal_op = 1, all other outputs 0. Remains in HALT until rst_n = 0.
- Cycle counts from FETCH, with mem_ready held at 1:
  - LW: 5 cycles
  - SW, RTYPE, ADDI: 4 cycles
  - BEQ, J: 3 cycles
- Each stall cycle with mem_ready = 0 adds exactly 1 cycle.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: outputs go to 0 immediately (asynchronous). No strobe may remain asserted while rst_n = 0.
- After rst_n deasserts: IDLE for 1 cycle, then FETCH.
- Write strobes (RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite) are never asserted in the same cycle as illegal_op.

Test Plan:
1. Reset release, mem_ready = 1, opcode = 6'b100011 (LW) → state sequence 0,1,2,3,4,5,1. instr_done high only in state 5. ALUOp = 00 in states 1, 2 and 3.
2. R-type, opcode = 0 → state sequence 1,2,7,8,1. ALUOp = 10 in EXEC. RegWrite = 1 and RegDst = 1 in ALUWB.
3. BEQ → state sequence 1,2,9,1. In BRANCH: ALUOp = 01, PCWriteCond = 1, PCSource = 01. J → JUMP with PCWrite = 1 and PCSource = 10.
4. SW with mem_ready low for 3 cycles in MEMWR → MemWrite held high for 4 cycles; instr_done pulses only on the cycle mem_ready = 1. FETCH stalled 2 cycles → PCWrite and IRWrite stay 0 until mem_ready = 1.
5. opcode = 6'b111111 at DECODE → HALT (15): illegal_op = 1 persistently, all strobes 0. Pulse rst_n → IDLE, then FETCH.
6. Assert rst_n = 0 asynchronously during MEMRD (mid-cycle) → MemRead and IorD drop before the next clock edge; state = 0.
